// File: rtl/sram_bank_pkg.sv
// Shared types and defaults for the multi-bank 2R1W SRAM subsystem.
// Holds the burst-loader state encoding, default geometry and the
// bank-select width helper.
package sram_bank_pkg;

  // Burst loader states
  // state   | meaning
  // IDLE    | waiting for ld_start, write ports belong to the datapath
  // LOAD    | streaming ld_data into the selected bank
  // DONE    | one-cycle completion pulse (ld_done)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  localparam int DEF_DATA_W    = 240;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_NUM_BANKS = 6;

  // Width of a bank index; a single bank still gets a 1-bit select.
  function automatic int calc_bank_w(input int num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/sram_2r1w.sv
// One SRAM bank: single write port, two independent registered read ports.
// Optional macro SRAM_WR_FWD_EN selects write-first behaviour for a read
// that hits the address written on the same edge; without it the bank is
// read-first (returns the pre-write word).
module sram_2r1w #(
  parameter int DATA_W = 240,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en1,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  output logic [DATA_W-1:0] o_rd_data1,
  input  logic              i_rd_en2,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data2
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data1;
  logic [DATA_W-1:0] r_rd_data2;

  // Array update; contents survive reset (gating is done by the caller).
  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port 1: registered, holds when not enabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_data1 <= '0;
    end else if (i_rd_en1) begin
`ifdef SRAM_WR_FWD_EN
      if (i_wr_en && (i_wr_addr == i_rd_addr1)) r_rd_data1 <= i_wr_data;
      else                                      r_rd_data1 <= r_mem[i_rd_addr1];
`else
      r_rd_data1 <= r_mem[i_rd_addr1];
`endif
    end
  end

  // Read port 2: identical to port 1, fully independent.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_data2 <= '0;
    end else if (i_rd_en2) begin
`ifdef SRAM_WR_FWD_EN
      if (i_wr_en && (i_wr_addr == i_rd_addr2)) r_rd_data2 <= i_wr_data;
      else                                      r_rd_data2 <= r_mem[i_rd_addr2];
`else
      r_rd_data2 <= r_mem[i_rd_addr2];
`endif
    end
  end

  assign o_rd_data1 = r_rd_data1;
  assign o_rd_data2 = r_rd_data2;

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank 2R1W SRAM subsystem with a burst loader that shares each
// bank's write port with the datapath (loader has priority on its bank).
// Optional macro SRAM_WR_FWD_EN (handled in sram_2r1w) makes same-edge
// read-during-write return the new data.
module sram_bank_array
  import sram_bank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  localparam int BANK_W   = calc_bank_w(NUM_BANKS),
  localparam int LEN_W    = ADDR_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ld_start,
  input  logic [BANK_W-1:0]           ld_bank,
  input  logic [ADDR_W-1:0]           ld_base,
  input  logic [LEN_W-1:0]            ld_len,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        ld_busy,
  output logic                        ld_done,
  output logic                        ld_err,
  input  logic [NUM_BANKS-1:0]        wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0] wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  output logic [NUM_BANKS-1:0]        wr_ready,
  input  logic [NUM_BANKS-1:0]        rd_en1,
  input  logic [NUM_BANKS-1:0]        rd_en2,
  input  logic [NUM_BANKS*ADDR_W-1:0] rd_addr1,
  input  logic [NUM_BANKS*ADDR_W-1:0] rd_addr2,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data1,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data2
);

  ld_state_t         r_state, w_state_nxt;
  logic [BANK_W-1:0] r_bank,  w_bank_nxt;
  logic [ADDR_W-1:0] r_ptr,   w_ptr_nxt;
  logic [LEN_W-1:0]  r_rem,   w_rem_nxt;
  logic              r_err,   w_err_nxt;
  logic              w_bank_ok;
  logic              w_len_ok;

  assign w_bank_ok = (32'(ld_bank) < 32'(NUM_BANKS));
  assign w_len_ok  = (ld_len != '0) && (ld_len <= LEN_W'(2**ADDR_W));

  // Loader state registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bank  <= w_bank_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Loader next-state: accept/reject starts, advance on each handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ld_start) begin
          if (w_bank_ok && w_len_ok) begin
            w_state_nxt = ST_LOAD;
            w_bank_nxt  = ld_bank;
            w_ptr_nxt   = ld_base;
            w_rem_nxt   = ld_len;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          w_ptr_nxt = r_ptr + 1'b1;
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == LEN_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs come straight from registered state.
  assign ld_ready = (r_state == ST_LOAD);
  assign ld_busy  = (r_state != ST_IDLE);
  assign ld_done  = (r_state == ST_DONE);
  assign ld_err   = r_err;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              w_ld_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_wa;
    logic [DATA_W-1:0] w_wd;

    // Loader owns the bank's write port for the whole LOAD phase, so the
    // datapath sees a stall even on ld_valid gaps.
    assign w_ld_sel    = (r_state == ST_LOAD) && (r_bank == BANK_W'(b));
    assign wr_ready[b] = ~w_ld_sel;
    // No writes land while reset is asserted.
    assign w_we = reset & (w_ld_sel ? ld_valid : wr_en[b]);
    assign w_wa = w_ld_sel ? r_ptr   : wr_addr[b*ADDR_W +: ADDR_W];
    assign w_wd = w_ld_sel ? ld_data : wr_data[b*DATA_W +: DATA_W];

    sram_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clock      (clock),
      .reset      (reset),
      .i_wr_en    (w_we),
      .i_wr_addr  (w_wa),
      .i_wr_data  (w_wd),
      .i_rd_en1   (rd_en1[b]),
      .i_rd_addr1 (rd_addr1[b*ADDR_W +: ADDR_W]),
      .o_rd_data1 (rd_data1[b*DATA_W +: DATA_W]),
      .i_rd_en2   (rd_en2[b]),
      .i_rd_addr2 (rd_addr2[b*ADDR_W +: ADDR_W]),
      .o_rd_data2 (rd_data2[b*DATA_W +: DATA_W])
    );
  end

endmodule
